fifo_umbral: RTL
================

FIFO_UMBRAL -- requirements
Module: fifo_umbral

Interface
REQ-001 SHALL have parameter DATA_W, default 6, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (power of two, at least 4).
REQ-003 SHALL have ports clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have ports reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports wr_en, input, 1, write request.
REQ-006 SHALL have ports data_in, input, DATA_W, write data.
REQ-007 SHALL have ports rd_en, input, 1, read request.
REQ-008 SHALL have ports umbral_load, input, 1, load thresholds.
REQ-009 SHALL have ports umbral_alto_in / umbral_bajo_in, input, log2(DEPTH)+1 each, almost-full / almost-empty thresholds.
REQ-010 SHALL have ports data_out, output, DATA_W, read data, registered.
REQ-011 SHALL have ports valid_out, output, 1, data_out holds a word this cycle.
REQ-012 SHALL have ports fifo_full / fifo_empty, output, 1 each, occupancy flags.
REQ-013 SHALL have ports almost_full / almost_empty, output, 1 each, threshold flags.
REQ-014 SHALL have ports error_out, output, 1, overflow/underflow indication.
REQ-015 SHALL have ports count, output, log2(DEPTH)+1, current occupancy.

Function
REQ-016 SHALL accept a write when wr_en=1 and the FIFO is not full (or when a read is accepted in the same cycle); count increments by 1.
REQ-017 SHALL accept a read when rd_en=1 and count>0; data_out and valid_out=1 appear on the next cycle (1-cycle latency); otherwise valid_out=0.
REQ-018 SHALL, on simultaneous accepted read and write, leave count unchanged; when full, both proceed.
REQ-019 SHALL treat simultaneous read and write on an empty FIFO as write accepted and read rejected (no bypass).
REQ-020 SHALL drop a write while full with no accepted read, with memory and count unchanged (overflow).
REQ-021 SHALL ignore a read while empty (underflow).
REQ-022 SHALL wrap the read and write pointers modulo DEPTH.
REQ-023 SHALL derive fifo_full (count==DEPTH) and fifo_empty (count==0) combinationally from registered count; never both 1.
REQ-024 SHALL set almost_full = (count >= umbral_alto) and almost_empty = (count <= umbral_bajo).
REQ-025 SHALL capture thresholds on umbral_load=1 only if umbral_bajo_in < umbral_alto_in <= DEPTH, and keep the previous values otherwise.
REQ-026 SHALL give umbral_load priority over nothing; data operations in the same cycle proceed normally.
REQ-027 SHALL drive error_out=1 for exactly the cycle following an overflow or underflow event (unless REQ-032 applies).

Reset
REQ-028 SHALL on reset=1 clear pointers and count to 0, and set data_out=0, valid_out=0, error_out=0, fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0.
REQ-029 SHALL on reset set umbral_alto=DEPTH-1 and umbral_bajo=1.
REQ-030 SHALL give reset priority over all simultaneous wr_en, rd_en and umbral_load, with in-flight data discarded; memory contents need not be cleared.

Configuration
REQ-031 SHALL provide macro FIFO_UMBRAL_ERR_STICKY_EN.
REQ-032 SHALL, when FIFO_UMBRAL_ERR_STICKY_EN is defined, hold error_out=1 from the first overflow/underflow until reset; when undefined, behave per REQ-027 as a one-cycle pulse.

Structure
REQ-033 SHALL place DATA_W/DEPTH defaults and the count-width constant in shared package fifo_umbral_pkg.
REQ-034 SHALL implement storage as sub-module ram_dp: one synchronous write port and one registered read port.

Verification
REQ-035 SHALL verify reset: after reset, count=0, fifo_empty=1, almost_empty=1, almost_full=0, error_out=0.
REQ-036 SHALL verify fill to full: 8 writes of 0x01..0x08 give count=8, fifo_full=1, and almost_full=1 from count 7; a 9th write gives error_out=1 and count stays 8.
REQ-037 SHALL verify drain: 8 reads return 0x01..0x08 in order, each one cycle after rd_en; a 9th read gives valid_out=0 and error_out=1.
REQ-038 SHALL verify wrap with simultaneous traffic: at count=8, wr_en=rd_en=1 for 10 cycles keeps count=8 with no error and correct data order across pointer wrap.
REQ-039 SHALL verify thresholds: load alto=5, bajo=2, then 5 writes set almost_full; loading alto=2, bajo=3 is rejected and thresholds stay 5/2.
REQ-040 SHALL verify reset mid-operation: with count=4, reset=1 together with wr_en=1 gives count=0 next cycle and valid_out=0.

Source files
------------

// File: rtl/fifo_umbral_pkg.sv
// rtl/fifo_umbral_pkg.sv - shared defaults and width helpers for fifo_umbral
//
// Purpose : default DATA_W / DEPTH for the threshold FIFO and the width of its
//           occupancy counter (log2(DEPTH)+1, so that count can reach DEPTH).
package fifo_umbral_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int DEPTH_DEF  = 8;
  localparam int CNT_W_DEF  = $clog2(DEPTH_DEF) + 1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_umbral_ram_dp.sv
// rtl/fifo_umbral_ram_dp.sv - dual-port storage for fifo_umbral
//
// Purpose : 2**AW x DATA_W memory, one synchronous write port and one
//           registered read port (read-before-write on address collision).
// Ports   : clk, reset     - clock, synchronous active-high reset (read reg only)
//           we/waddr/wdata - write port
//           re/raddr       - read request; rdata updates on the next edge
//           rdata          - registered read data, holds when re=0
module ram_dp #(
  parameter int DATA_W = 6,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] rdata_q;

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - synchronous FIFO with programmable almost-full/almost-empty thresholds
//
// Purpose : single-clock FIFO, 1-cycle read latency, loadable thresholds,
//           overflow/underflow error flag.
// Macro   : FIFO_UMBRAL_ERR_STICKY_EN - when defined, error_out stays high from
//           the first overflow/underflow until reset; otherwise a 1-cycle pulse.
// Ports   : clk, reset (sync, active high)
//           wr_en/data_in             - write side
//           rd_en -> data_out/valid_out one cycle later
//           umbral_load, umbral_alto_in, umbral_bajo_in - threshold load
//           fifo_full, fifo_empty, almost_full, almost_empty, count, error_out
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   rd_en,
  input  logic                   umbral_load,
  input  logic [$clog2(DEPTH):0] umbral_alto_in,
  input  logic [$clog2(DEPTH):0] umbral_bajo_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   valid_out,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   error_out,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] alto_q, alto_d, bajo_q, bajo_d;
  logic          valid_q, err_q, err_d;
  logic          wr_acc, rd_acc, overflow, underflow, load_ok;

  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);

  // A read is accepted only with data present; a write on a full FIFO is
  // accepted when a read frees the slot in the same cycle.
  assign rd_acc    = rd_en && !fifo_empty;
  assign wr_acc    = wr_en && (!fifo_full || rd_acc);
  assign overflow  = wr_en && fifo_full && !rd_acc;
  assign underflow = rd_en && fifo_empty;

  assign load_ok = umbral_load && (umbral_bajo_in < umbral_alto_in)
                   && (umbral_alto_in <= CW'(DEPTH));

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    alto_d  = alto_q;
    bajo_d  = bajo_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (!wr_acc && rd_acc) count_d = count_q - 1'b1;
    if (load_ok) begin
      alto_d = umbral_alto_in;
      bajo_d = umbral_bajo_in;
    end
`ifdef FIFO_UMBRAL_ERR_STICKY_EN
    err_d = err_q || overflow || underflow;
`else
    err_d = overflow || underflow;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      alto_q  <= CW'(DEPTH - 1);
      bajo_q  <= CW'(1);
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      alto_q  <= alto_d;
      bajo_q  <= bajo_d;
      valid_q <= rd_acc;
      err_q   <= err_d;
    end
  end

  ram_dp #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wptr_q),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rptr_q),
    .rdata (data_out)
  );

  assign valid_out    = valid_q;
  assign error_out    = err_q;
  assign count        = count_q;
  assign almost_full  = (count_q >= alto_q);
  assign almost_empty = (count_q <= bajo_q);

endmodule
